cpu_bus_arbiter: RTL

- Sits directly downstream of the cpu core and consumes its two physical bus masters: the fetch-side MMU bus (if) and the access-side MMU bus (ma), each qualified by its request line.
- Merges them onto a single TileLink-UL style memory port toward the interconnect.
- Locks the grant per transaction and holds at most one outstanding transaction.
- Routes each D-channel response back only to the owning master.

---
 rtl/cpu_bus_pkg.sv | 36 +++
 rtl/rr_arb2.sv | 36 +++
 rtl/cpu_bus_arbiter.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_bus_pkg
// Description : Shared types and constants for the cpu bus arbiter slice.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_bus_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        A_PHASE = 2'd1,
        D_PHASE = 2'd2,
        DRAIN   = 2'd3
    } arb_state_t;

    localparam logic [2:0] TL_GET     = 3'd4;
    localparam logic [2:0] TL_PUTFULL = 3'd0;

    localparam logic SRC_IF = 1'b0;
    localparam logic SRC_MA = 1'b1;

    // Two-requester round-robin choice: contention goes to whoever was not served last.
    function automatic logic rr_pick(input logic req_if, input logic req_ma, input logic last_owner);
        logic pick;
        if (req_if && req_ma) begin
            pick = ~last_owner;
        end else if (req_ma) begin
            pick = SRC_MA;
        end else begin
            pick = SRC_IF;
        end
        return pick;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-requester round-robin picker with a last-owner register.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
    import cpu_bus_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_req_if,
    input  logic i_req_ma,
    input  logic i_update,
    input  logic i_update_src,
    output logic o_grant,
    output logic o_grant_src
);

    logic r_last_owner;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_owner <= SRC_IF;
        end else if (i_update) begin
            r_last_owner <= i_update_src;
        end
    end

    always_comb begin
        o_grant     = i_req_if | i_req_ma;
        o_grant_src = rr_pick(i_req_if, i_req_ma, r_last_owner);
    end

endmodule
`default_nettype wire

// File: rtl/cpu_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cpu_bus_arbiter
// Description : Merges the fetch and access MMU buses onto one TileLink-UL port,
//               one outstanding transaction, responses routed to the owner.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_bus_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int MASK_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,

    input  logic              if_request,
    input  logic              if_a_valid,
    output logic              if_a_ready,
    input  logic [2:0]        if_a_opcode,
    input  logic [ADDR_W-1:0] if_a_address,
    input  logic [DATA_W-1:0] if_a_data,
    input  logic [MASK_W-1:0] if_a_mask,
    output logic              if_d_valid,
    input  logic              if_d_ready,
    output logic [DATA_W-1:0] if_d_data,
    output logic              if_d_error,

    input  logic              ma_request,
    input  logic              ma_a_valid,
    output logic              ma_a_ready,
    input  logic [2:0]        ma_a_opcode,
    input  logic [ADDR_W-1:0] ma_a_address,
    input  logic [DATA_W-1:0] ma_a_data,
    input  logic [MASK_W-1:0] ma_a_mask,
    output logic              ma_d_valid,
    input  logic              ma_d_ready,
    output logic [DATA_W-1:0] ma_d_data,
    output logic              ma_d_error,

    output logic              mem_a_valid,
    input  logic              mem_a_ready,
    output logic [2:0]        mem_a_opcode,
    output logic [ADDR_W-1:0] mem_a_address,
    output logic [DATA_W-1:0] mem_a_data,
    output logic [MASK_W-1:0] mem_a_mask,
    output logic              mem_a_source,
    input  logic              mem_d_valid,
    output logic              mem_d_ready,
    input  logic [DATA_W-1:0] mem_d_data,
    input  logic              mem_d_error,

    output logic              busy
);

    arb_state_t r_state;
    arb_state_t w_next_state;
    logic       r_owner;

    logic       w_arb_grant;
    logic       w_arb_src;
    logic       w_rr_update;

    logic       w_own_req;
    logic       w_own_a_valid;
    logic       w_own_d_ready;
    logic       w_a_fire;
    logic       w_d_fire;

    rr_arb2 u_rr_arb2 (
        .clk          (clk),
        .rst          (rst),
        .i_req_if     (if_request),
        .i_req_ma     (ma_request),
        .i_update     (w_rr_update),
        .i_update_src (r_owner),
        .o_grant      (w_arb_grant),
        .o_grant_src  (w_arb_src)
    );

    assign w_own_req     = (r_owner == SRC_MA) ? ma_request : if_request;
    assign w_own_a_valid = (r_owner == SRC_MA) ? ma_a_valid : if_a_valid;
    assign w_own_d_ready = (r_owner == SRC_MA) ? ma_d_ready : if_d_ready;
    assign w_a_fire      = (r_state == A_PHASE) && w_own_a_valid && mem_a_ready;
    assign w_d_fire      = (r_state == D_PHASE) && mem_d_valid && w_own_d_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_owner <= SRC_IF;
        end else begin
            r_state <= w_next_state;
            if ((r_state == IDLE) && w_arb_grant) begin
                r_owner <= w_arb_src;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_rr_update  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_arb_grant) begin
                    w_next_state = A_PHASE;
                end
            end
            A_PHASE: begin
                // A beat already accepted by memory means a response is owed: drain it.
                if (clear) begin
                    w_next_state = w_a_fire ? DRAIN : IDLE;
                end else if (w_a_fire) begin
                    w_next_state = D_PHASE;
                end else if (!w_own_req && !w_own_a_valid) begin
                    w_next_state = IDLE;
                end
            end
            D_PHASE: begin
                // A response consumed in the same cycle as clear completes the transaction.
                if (w_d_fire) begin
                    w_next_state = IDLE;
                    w_rr_update  = 1'b1;
                end else if (clear) begin
                    w_next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (mem_d_valid) begin
                    w_next_state = IDLE;
                    w_rr_update  = 1'b1;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_comb begin
        mem_a_valid   = 1'b0;
        mem_a_opcode  = '0;
        mem_a_address = '0;
        mem_a_data    = '0;
        mem_a_mask    = '0;
        mem_a_source  = r_owner;
        mem_d_ready   = 1'b0;
        if_a_ready    = 1'b0;
        ma_a_ready    = 1'b0;
        if_d_valid    = 1'b0;
        ma_d_valid    = 1'b0;
        if_d_data     = '0;
        ma_d_data     = '0;
        if_d_error    = 1'b0;
        ma_d_error    = 1'b0;
        busy          = (r_state != IDLE);

        case (r_state)
            A_PHASE: begin
                mem_a_valid = w_own_a_valid;
                if (r_owner == SRC_MA) begin
                    mem_a_opcode  = ma_a_opcode;
                    mem_a_address = ma_a_address;
                    mem_a_data    = ma_a_data;
                    mem_a_mask    = ma_a_mask;
                    ma_a_ready    = mem_a_ready;
                end else begin
                    mem_a_opcode  = if_a_opcode;
                    mem_a_address = if_a_address;
                    mem_a_data    = if_a_data;
                    mem_a_mask    = if_a_mask;
                    if_a_ready    = mem_a_ready;
                end
            end
            D_PHASE: begin
                mem_d_ready = w_own_d_ready;
                if (r_owner == SRC_MA) begin
                    ma_d_valid = mem_d_valid;
                    ma_d_data  = mem_d_data;
                    ma_d_error = mem_d_error;
                end else begin
                    if_d_valid = mem_d_valid;
                    if_d_data  = mem_d_data;
                    if_d_error = mem_d_error;
                end
            end
            DRAIN: begin
                mem_d_ready = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire
